// File: rtl/led_pkg.sv
// Shared types and the colour table for the RGB fade sequencer.
// Table entries are {R,G,B}, 8 bits per channel, indexed by colour_idx.
package led_pkg;

    typedef logic [2:0] color_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        FADE,
        STEADY
    } fade_state_t;

    // Leftmost entry is index 7, rightmost is index 0.
    localparam logic [7:0][23:0] COLOR_TABLE = {
        24'h000000,  // 7 off
        24'hFFFFFF,  // 6 white
        24'hFF00FF,  // 5 magenta
        24'h0000FF,  // 4 blue
        24'h00FFFF,  // 3 cyan
        24'h00FF00,  // 2 green
        24'hFFFF00,  // 1 yellow
        24'hFF0000   // 0 red
    };

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: registered duty that steps toward a target on each
// advance strobe, saturating exactly at the target, plus the PWM compare.
module pwm_channel #(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                advance,
    input  logic [PWM_BITS-1:0] target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                at_target
);

    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_step;

    always_comb begin
        duty_step = duty_q;
        if (duty_q < target) begin
            duty_step = ((target - duty_q) <= STEP) ? target : duty_q + STEP;
        end else if (duty_q > target) begin
            duty_step = ((duty_q - target) <= STEP) ? target : duty_q - STEP;
        end
    end

    // True when the duty equals the target once this advance is applied,
    // so the sequencer can settle on the same wrap edge.
    assign at_target = (duty_step == target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else if (clear) begin
            duty_q <= '0;
        end else if (advance) begin
            duty_q <= duty_step;
        end
    end

    assign led = (pwm_cnt < duty_q);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Steps through the colour table on timer pulses and fades the three PWM
// duties linearly toward each new colour, one move per PWM period.
//
// state  | meaning
// IDLE   | disabled, duties held at 0, LEDs dark
// FADE   | at least one channel still moving toward its target
// STEADY | all channels at target, waiting for the next step
module rgb_fade_sequencer
    import led_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       step,
    output logic       led_R,
    output logic       led_G,
    output logic       led_B,
    output logic [2:0] color_idx,
    output logic       busy
);

    fade_state_t         state_q;
    fade_state_t         state_d;
    color_idx_t          color_idx_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                wrap;
    logic                advance;
    logic                clear;
    logic                step_ok;
    logic [7:0]          tbl_r;
    logic [7:0]          tbl_g;
    logic [7:0]          tbl_b;
    logic [PWM_BITS-1:0] tgt_r;
    logic [PWM_BITS-1:0] tgt_g;
    logic [PWM_BITS-1:0] tgt_b;
    logic                at_r;
    logic                at_g;
    logic                at_b;

    assign wrap    = &pwm_cnt;
    assign clear   = !enable;
    assign step_ok = enable && step;
    assign advance = wrap && (state_q == FADE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_idx_q <= '0;
        end else if (step_ok) begin
            color_idx_q <= color_idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Adjacent table entries always differ, so an accepted step always
    // changes the target and must keep (or put) the FSM in FADE.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = FADE;
                FADE:    if (wrap && !step_ok && at_r && at_g && at_b) state_d = STEADY;
                STEADY:  if (step_ok) state_d = FADE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign {tbl_r, tbl_g, tbl_b} = COLOR_TABLE[color_idx_q];
    assign tgt_r = PWM_BITS'(tbl_r >> (8 - PWM_BITS));
    assign tgt_g = PWM_BITS'(tbl_g >> (8 - PWM_BITS));
    assign tgt_b = PWM_BITS'(tbl_b >> (8 - PWM_BITS));

    pwm_channel #(.PWM_BITS(PWM_BITS), .FADE_STEP(FADE_STEP)) u_ch_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .advance   (advance),
        .target    (tgt_r),
        .pwm_cnt   (pwm_cnt),
        .led       (led_R),
        .at_target (at_r)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS), .FADE_STEP(FADE_STEP)) u_ch_g (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .advance   (advance),
        .target    (tgt_g),
        .pwm_cnt   (pwm_cnt),
        .led       (led_G),
        .at_target (at_g)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS), .FADE_STEP(FADE_STEP)) u_ch_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .advance   (advance),
        .target    (tgt_b),
        .pwm_cnt   (pwm_cnt),
        .led       (led_B),
        .at_target (at_b)
    );

    assign color_idx = color_idx_q;
    assign busy      = (state_q == FADE);

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer at PWM_BITS=4, FADE_STEP=4.
// Each period is summarised as {R,G,B,busy} high-cycle counts, one byte each.
module tb_rgb_fade_sequencer;

    localparam int PWM_BITS  = 4;
    localparam int FADE_STEP = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       enable = 1'b0;
    logic       step   = 1'b0;
    logic       led_R;
    logic       led_G;
    logic       led_B;
    logic [2:0] color_idx;
    logic       busy;

    logic [3:0] ph;
    int         checks = 0;
    int         errors = 0;

    rgb_fade_sequencer #(.PWM_BITS(PWM_BITS), .FADE_STEP(FADE_STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .step      (step),
        .led_R     (led_R),
        .led_G     (led_G),
        .led_B     (led_B),
        .color_idx (color_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Bench copy of the PWM phase: counts edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph <= 4'd0;
        else        ph <= ph + 4'd1;
    end

    task automatic wait_ph(input int p);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ph == p[3:0]) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_ph: phase %0d not seen within 40 cycles", p);
    endtask

    task automatic measure(output logic [31:0] res);
        logic [7:0] r, g, b, bz;
        r = 8'd0; g = 8'd0; b = 8'd0; bz = 8'd0;
        wait_ph(0);
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            r  = r  + {7'd0, led_R};
            g  = g  + {7'd0, led_G};
            b  = b  + {7'd0, led_B};
            bz = bz + {7'd0, busy};
        end
        res = {r, g, b, bz};
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({led_R, led_G, led_B, busy, color_idx} !== 7'd0) begin
            errors++;
            $display("FAIL reset_values: leds/busy/idx %b, expected 0000000",
                     {led_R, led_G, led_B, busy, color_idx});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({led_R, led_G, led_B, busy, color_idx} !== 7'd0) begin
            errors++;
            $display("FAIL idle_after_reset: leds/busy/idx %b, expected 0000000",
                     {led_R, led_G, led_B, busy, color_idx});
        end
    endtask

    task automatic test_fade_from_idle();
        logic [31:0] exp_p [5] = '{32'h00000010, 32'h04000010, 32'h08000010,
                                   32'h0C000010, 32'h0F000000};
        logic [31:0] res;
        wait_ph(15);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            measure(res);
            checks++;
            if (res !== exp_p[i]) begin
                errors++;
                $display("FAIL fade_from_idle p%0d: counts %h, expected %h", i, res, exp_p[i]);
            end
        end
        checks++;
        if (color_idx !== 3'd0) begin
            errors++;
            $display("FAIL fade_from_idle_idx: idx %0d, expected 0", color_idx);
        end
    endtask

    // Step lands on a wrap edge: that wrap uses the old target, so G starts at 0.
    task automatic test_step_steady();
        logic [31:0] exp_p [5] = '{32'h0F000010, 32'h0F040010, 32'h0F080010,
                                   32'h0F0C0010, 32'h0F0F0000};
        logic [31:0] res;
        pulse_step();
        for (int i = 0; i < 5; i++) begin
            measure(res);
            checks++;
            if (res !== exp_p[i]) begin
                errors++;
                $display("FAIL step_yellow p%0d: counts %h, expected %h", i, res, exp_p[i]);
            end
        end
        checks++;
        if (color_idx !== 3'd1) begin
            errors++;
            $display("FAIL step_yellow_idx: idx %0d, expected 1", color_idx);
        end
    endtask

    task automatic test_disable_mid_fade();
        logic [31:0] exp_p [2] = '{32'h0F0F0010, 32'h0B0F0010};
        logic [31:0] res;
        pulse_step();
        for (int i = 0; i < 2; i++) begin
            measure(res);
            checks++;
            if (res !== exp_p[i]) begin
                errors++;
                $display("FAIL fade_down_green p%0d: counts %h, expected %h", i, res, exp_p[i]);
            end
        end
        wait_ph(5);
        checks++;
        if ({led_R, led_G, led_B, busy} !== 4'b1101) begin
            errors++;
            $display("FAIL pre_disable: R/G/B/busy %b, expected 1101", {led_R, led_G, led_B, busy});
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({led_R, led_G, led_B, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL disable_dark: R/G/B/busy %b, expected 0000", {led_R, led_G, led_B, busy});
        end
        checks++;
        if (color_idx !== 3'd2) begin
            errors++;
            $display("FAIL disable_idx: idx %0d, expected 2", color_idx);
        end
        pulse_step();
        pulse_step();
        @(negedge clk);
        checks++;
        if (color_idx !== 3'd2) begin
            errors++;
            $display("FAIL step_while_disabled: idx %0d, expected 2", color_idx);
        end
        measure(res);
        checks++;
        if (res !== 32'h00000000) begin
            errors++;
            $display("FAIL disabled_period: counts %h, expected 00000000", res);
        end
    endtask

    // Re-enable at idx 2 (from duty 0), then step to cyan while G is at 8.
    task automatic test_mid_fade_step();
        logic [31:0] exp_a [3] = '{32'h00000010, 32'h00040010, 32'h00080010};
        logic [31:0] exp_b [5] = '{32'h000C0010, 32'h000F0410, 32'h000F0810,
                                   32'h000F0C10, 32'h000F0F00};
        logic [31:0] res;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            measure(res);
            checks++;
            if (res !== exp_a[i]) begin
                errors++;
                $display("FAIL reenable_green p%0d: counts %h, expected %h", i, res, exp_a[i]);
            end
        end
        pulse_step();
        for (int i = 0; i < 5; i++) begin
            measure(res);
            checks++;
            if (res !== exp_b[i]) begin
                errors++;
                $display("FAIL mid_fade_cyan p%0d: counts %h, expected %h", i, res, exp_b[i]);
            end
        end
        checks++;
        if (color_idx !== 3'd3) begin
            errors++;
            $display("FAIL mid_fade_idx: idx %0d, expected 3", color_idx);
        end
    endtask

    task automatic test_reset_mid_fade();
        logic [31:0] res;
        pulse_step();
        pulse_step();
        @(negedge clk);
        checks++;
        if ({color_idx, busy, led_R, led_G, led_B} !== {3'd5, 4'b1011}) begin
            errors++;
            $display("FAIL before_reset: idx/busy/R/G/B %b, expected 1011011",
                     {color_idx, busy, led_R, led_G, led_B});
        end
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        checks++;
        if ({color_idx, busy, led_R, led_G, led_B} !== 7'd0) begin
            errors++;
            $display("FAIL async_reset: idx/busy/R/G/B %b, expected 0000000",
                     {color_idx, busy, led_R, led_G, led_B});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure(res);
        checks++;
        if (res !== 32'h00000000 || color_idx !== 3'd0) begin
            errors++;
            $display("FAIL idle_after_release: counts %h idx %0d, expected 00000000 idx 0", res, color_idx);
        end
    endtask

    task automatic test_index_wrap();
        logic [31:0] res;
        enable = 1'b1;
        for (int i = 1; i < 8; i++) begin
            pulse_step();
            @(negedge clk);
            checks++;
            if (color_idx !== 3'(i)) begin
                errors++;
                $display("FAIL index_seq: idx %0d, expected %0d", color_idx, i);
            end
        end
        res = 32'hFFFFFFFF;
        for (int k = 0; k < 10; k++) begin
            measure(res);
            if (res[7:0] == 8'd0) break;
        end
        checks++;
        if (res !== 32'h00000000) begin
            errors++;
            $display("FAIL off_settled: counts %h, expected 00000000", res);
        end
        pulse_step();
        @(negedge clk);
        checks++;
        if ({color_idx, busy} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL index_wrap: idx %0d busy %b, expected idx 0 busy 1", color_idx, busy);
        end
    endtask

    initial begin
        test_reset();
        test_fade_from_idle();
        test_step_steady();
        test_disable_mid_fade();
        test_mid_fade_step();
        test_reset_mid_fade();
        test_index_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Downstream consumer of the board's blink-rate timer. It takes a one-cycle `step` pulse, advances through a fixed 8-colour table, and drives the RGB LED pins with per-channel PWM. Brightness ramps linearly between colours rather than snapping. It replaces direct LED toggling at the top level.

## Interface
- `PWM_BITS`, default 8: PWM counter and duty width; legal range 2..8.
- `FADE_STEP`, default 8: duty increment/decrement per PWM period; must be ≥1 and < 2^PWM_BITS.
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: sequencer run; 0 forces LEDs dark.
- `step` in 1: single-cycle advance pulse from the timer.
- `led_R` / `led_G` / `led_B` out 1 each: PWM LED drives, active-high.
- `color_idx` out 3: current colour table index.
- `busy` out 1: high while any channel is still fading.

## Operation
- Colour table, 8-bit per channel R,G,B:
  - 0 red FF,00,00
  - 1 yellow FF,FF,00
  - 2 green 00,FF,00
  - 3 cyan 00,FF,FF
  - 4 blue 00,00,FF
  - 5 magenta FF,00,FF
  - 6 white FF,FF,FF
  - 7 off 00,00,00
- Target duty per channel = table value >> (8 − PWM_BITS).
- PWM counter is free-running, 0..2^PWM_BITS−1, and wraps to 0. The "wrap cycle" is the cycle where the counter equals all-ones.
- Each channel has a registered duty; `led_X = (pwm_cnt < duty_X)`.
  - Duty 0 means fully off.
  - All-ones duty means on for 2^PWM_BITS−1 of 2^PWM_BITS cycles.
- FSM states:
  - IDLE: `enable`=0.
  - FADE: any duty ≠ target.
  - STEADY: all duties = target.
- FSM transitions:
  - IDLE→FADE when `enable` rises.
  - FADE→STEADY at the wrap cycle where the last channel reaches target.
  - STEADY→FADE when `step` changes the target.
  - Any state→IDLE when `enable`=0.
- Fade rule, on each wrap cycle in FADE, per channel:
  - duty moves FADE_STEP toward target.
  - It saturates exactly at target and never overshoots.
  - Channels are independent.
- `step` with `enable`=1: `color_idx` increments modulo 8 (7→0).
- `step` with `enable`=0: ignored.
- `step` mid-fade: the target updates and the fade continues from the current duties toward the new target. There is no restart from 0.
- Entering IDLE: all duties cleared to 0 immediately; `color_idx` is retained.
- Leaving IDLE: fade starts from duty 0 toward `table[color_idx]`.
- `busy` = (state == FADE).

## Timing
- Reset values:
  - `pwm_cnt`=0, all duties=0, state=IDLE.
  - `color_idx`=0; `led_*`=0; `busy`=0.
- `step` sampled at posedge clk; `color_idx` and target update on the same edge and are visible the next cycle.
- Duty changes only on wrap-cycle edges, so a PWM period is never truncated.
  - Exception: the clear on entry to IDLE, which happens on the edge `enable`=0 is sampled.
  - `led_*` therefore drop to 0 on the following cycle.
- `step` coinciding with a wrap cycle: the wrap-cycle duty move uses the old target; the new target applies from the next wrap.
- `step` and `enable` falling in the same cycle: IDLE wins and `color_idx` does not advance.
- `rst_n` asserted mid-fade: all outputs go to reset values asynchronously.
- Fade latency from duty 0 to full: ceil((2^PWM_BITS−1)/FADE_STEP) PWM periods.

## Structure
- Package `led_pkg`:
  - colour table constant (8×24-bit)
  - FSM state enum (IDLE, FADE, STEADY)
  - colour index type (3-bit)
- Sub-module `pwm_channel`, instantiated ×3:
  - duty register with saturating step toward target on a `wrap` strobe
  - synchronous clear
  - compare output
  - `at_target` flag
- Top module holds the PWM counter, FSM and index.

## Test plan
All tests use PWM_BITS=4, FADE_STEP=4 (period 16 cycles).
- Reset then `enable`=1, no step → R duty 0→4→8→12→15 over 4 wraps; G=B=0; `busy` high throughout, low after the 4th wrap; then `led_R` is high 15 of 16 cycles.
- STEADY red, one `step` → `color_idx`=1, G ramps 0,4,8,12,15 while R holds 15; `busy` high for 4 periods.
- Eight `step` pulses with `enable`=1 → `color_idx` sequence 1..7,0 (wraps); after idx 7 settles, all `led_*` constant 0.
- Mid-fade: G at 8 toward 15, `step` to cyan (idx 3) → G continues 12,15 and B ramps from 0; no channel resets.
- `enable` dropped at idx 2 mid-fade → `led_*`=0 from the next cycle, `busy`=0, `color_idx` stays 2; `step` pulses while disabled leave the index at 2.
- `rst_n` low during FADE at idx 5 → all outputs 0 and `color_idx`=0 immediately; after release, the module is idle until `enable`=1.
